// File: rtl/md5_candidate_tracker.sv
// md5_candidate_tracker
//
// Runs a brute-force MD5 password search. It sits between the printable
// UTF-16LE chunk generator and the pipelined MD5 core. Each candidate chunk
// enters a delay line that matches the hash latency, so every digest coming
// out of the core is compared against the chunk that produced it. On a match
// the decoded password is latched and the search halts. If the generator runs
// dry (all-zero chunk), the in-flight candidates drain before the block
// reports exhaustion.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-low
//   start       pulse: begin a new search (ignored while busy)
//   abort       pulse: cancel and return to IDLE (wins over start)
//   target      128-bit digest to match, stable while busy
//   chunk_in    512-bit generator chunk
//   digest_in   hash core output for the chunk seen LATENCY cycles earlier
//   gen_run     generator active-low reset (0 holds the generator cleared)
//   busy        high in RUN or DRAIN
//   found       sticky match flag
//   exhausted   sticky "search space ended with no match" flag
//   password    matched UTF-16LE bytes, byte 0 at [7:0], unused bytes zero
//   pw_len      matched length in characters
//   candidates  saturating count of valid chunks pushed

module md5_candidate_tracker #(
  parameter int LATENCY = 64,
  parameter int CNT_W   = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [127:0]     target,
  input  logic [511:0]     chunk_in,
  input  logic [127:0]     digest_in,
  output logic             gen_run,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [255:0]     password,
  output logic [4:0]       pw_len,
  output logic [CNT_W-1:0] candidates
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FOUND, EXHAUSTED} state_t;

  state_t state;

  logic [LATENCY-1:0] dl_valid;
  logic [255:0]       dl_bytes [LATENCY];
  logic [4:0]         dl_len   [LATENCY];

  logic               run_prev;
  logic               push_valid;
  logic [4:0]         push_len;
  logic               gen_empty;
  logic               hit;
  logic               all_clear;
  logic [255:0]       tail_bytes;
  logic [4:0]         tail_len;
  logic [255:0]       masked;

  // The size word holds the message length in bits; 16 bits per UTF-16
  // character, so bits [8:4] of the size word are the character count.
  assign push_len   = chunk_in[456:452];
  assign push_valid = (state == RUN) && (chunk_in[479:448] != 32'd0);

  // The generator's reset value is all-zero, so a zero chunk only means
  // "done" once the generator has been out of reset for at least one cycle.
  assign gen_empty  = run_prev && (chunk_in == '0);

  assign tail_bytes = dl_bytes[LATENCY-1];
  assign tail_len   = dl_len[LATENCY-1];
  assign hit        = dl_valid[LATENCY-1] && (digest_in == target) &&
                      ((state == RUN) || (state == DRAIN));
  assign all_clear  = (dl_valid == '0);

  // Keep only the first 2*len bytes; the rest is padding and size word.
  always_comb begin
    masked = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 2 * int'(tail_len)) masked[8*i +: 8] = tail_bytes[8*i +: 8];
    end
  end

  // Delay-line payload shifts every cycle. Only the valid bits need reset.
  always_ff @(posedge clk) begin
    dl_bytes[0] <= chunk_in[255:0];
    dl_len[0]   <= push_len;
    for (int i = 1; i < LATENCY; i++) begin
      dl_bytes[i] <= dl_bytes[i-1];
      dl_len[i]   <= dl_len[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dl_valid   <= '0;
      run_prev   <= 1'b0;
      gen_run    <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      password   <= '0;
      pw_len     <= '0;
      candidates <= '0;
    end else begin
      run_prev    <= gen_run;
      dl_valid[0] <= push_valid;
      for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];

      if (abort) begin
        state    <= IDLE;
        gen_run  <= 1'b0;
        busy     <= 1'b0;
        dl_valid <= '0;
      end else begin
        case (state)
          IDLE, FOUND, EXHAUSTED: begin
            if (start) begin
              state      <= RUN;
              gen_run    <= 1'b1;
              busy       <= 1'b1;
              found      <= 1'b0;
              exhausted  <= 1'b0;
              candidates <= '0;
              dl_valid   <= '0;
            end
          end
          RUN, DRAIN: begin
            if (push_valid && (candidates != '1))
              candidates <= candidates + CNT_W'(1);
            // A hit outranks both exhaustion and the drain completing.
            if (hit) begin
              state    <= FOUND;
              gen_run  <= 1'b0;
              busy     <= 1'b0;
              found    <= 1'b1;
              password <= masked;
              pw_len   <= tail_len;
              dl_valid <= '0;
            end else if ((state == RUN) && gen_empty) begin
              state   <= DRAIN;
              gen_run <= 1'b0;
            end else if ((state == DRAIN) && all_clear) begin
              state     <= EXHAUSTED;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md5_candidate_tracker.sv
// tb_md5_candidate_tracker
//
// Directed bench for md5_candidate_tracker with a short delay line
// (LATENCY=4). Inputs change on the falling edge; outputs are checked on the
// following falling edge, after the rising edge has taken effect.

module tb_md5_candidate_tracker;

  localparam int LATENCY = 4;
  localparam int CNT_W   = 48;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [127:0]     target;
  logic [511:0]     chunk_in;
  logic [127:0]     digest_in;
  logic             gen_run;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic [255:0]     password;
  logic [4:0]       pw_len;
  logic [CNT_W-1:0] candidates;

  int errors = 0;
  int checks = 0;

  logic [511:0] c_a, c_abc, c_fill;
  logic [127:0] tgt_a, tgt_abc, tgt_none;

  md5_candidate_tracker #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .target     (target),
    .chunk_in   (chunk_in),
    .digest_in  (digest_in),
    .gen_run    (gen_run),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .password   (password),
    .pw_len     (pw_len),
    .candidates (candidates)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] make_chunk(input logic [255:0] bytes, input logic [31:0] size);
    logic [511:0] c;
    c = '0;
    c[255:0]   = bytes;
    c[479:448] = size;
    return c;
  endfunction

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then wait until the next falling edge.
  task automatic apply_stimulus(input logic s, input logic a, input logic [511:0] c, input logic [127:0] d);
    start     = s;
    abort     = a;
    chunk_in  = c;
    digest_in = d;
    @(negedge clk);
  endtask

  initial begin
    c_a      = make_chunk(256'h80_0041, 32'd16);
    c_abc    = make_chunk(256'h80_006300620061, 32'd48);
    c_fill   = 512'h1;
    tgt_a    = 128'h0123456789abcdef_fedcba9876543210;
    tgt_abc  = 128'h55aa55aa12345678_9abcdef011223344;
    tgt_none = 128'hdeadbeefcafef00d_0badf00d8badf00d;

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    chunk_in = '0; digest_in = '0; target = tgt_a;
    #2;
    $display("[TB] reset state");
    check_output("rst_gen_run", 256'(gen_run), 256'd0);
    check_output("rst_busy", 256'(busy), 256'd0);
    check_output("rst_found", 256'(found), 256'd0);
    check_output("rst_exhausted", 256'(exhausted), 256'd0);
    check_output("rst_password", password, 256'd0);
    check_output("rst_candidates", 256'(candidates), 256'd0);
    @(negedge clk);
    reset = 1'b1;

    // Match on the first candidate 'A'
    $display("[TB] match on first candidate");
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t1_gen_run_start", 256'(gen_run), 256'd1);
    check_output("t1_busy_start", 256'(busy), 256'd1);
    check_output("t1_cand_start", 256'(candidates), 256'd0);
    apply_stimulus(1'b0, 1'b0, c_a, '0);
    check_output("t1_cand_push", 256'(candidates), 256'd1);
    apply_stimulus(1'b0, 1'b0, c_fill, '0);
    apply_stimulus(1'b0, 1'b0, c_fill, '0);
    apply_stimulus(1'b0, 1'b0, c_fill, '0);
    check_output("t1_found_early", 256'(found), 256'd0);
    check_output("t1_gen_run_fill", 256'(gen_run), 256'd1);
    apply_stimulus(1'b0, 1'b0, c_fill, tgt_a);
    check_output("t1_found", 256'(found), 256'd1);
    check_output("t1_pw_len", 256'(pw_len), 256'd1);
    check_output("t1_password", password, 256'h0041);
    check_output("t1_gen_run", 256'(gen_run), 256'd0);
    check_output("t1_busy", 256'(busy), 256'd0);
    check_output("t1_cand", 256'(candidates), 256'd1);
    apply_stimulus(1'b0, 1'b0, c_fill, tgt_a);
    check_output("t1_found_hold", 256'(found), 256'd1);

    // Ten misses, then the generator runs dry
    $display("[TB] exhaustion");
    target = tgt_none;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t2_found_clr", 256'(found), 256'd0);
    check_output("t2_cand_clr", 256'(candidates), 256'd0);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1'b0, 1'b0, make_chunk(256'(i + 1), 32'd16), '0);
    check_output("t2_cand_10", 256'(candidates), 256'd10);
    check_output("t2_gen_run_on", 256'(gen_run), 256'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t2_gen_run_drop", 256'(gen_run), 256'd0);
    check_output("t2_busy_drain", 256'(busy), 256'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t2_exh_early", 256'(exhausted), 256'd0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t2_exhausted", 256'(exhausted), 256'd1);
    check_output("t2_found", 256'(found), 256'd0);
    check_output("t2_busy", 256'(busy), 256'd0);
    check_output("t2_cand_final", 256'(candidates), 256'd10);

    // Last candidate before the zero chunk matches while draining
    $display("[TB] hit during drain with masking");
    target = tgt_abc;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t3_exh_clr", 256'(exhausted), 256'd0);
    apply_stimulus(1'b0, 1'b0, c_abc, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t3_gen_run_drain", 256'(gen_run), 256'd0);
    check_output("t3_busy_drain", 256'(busy), 256'd1);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, tgt_abc);
    check_output("t3_found", 256'(found), 256'd1);
    check_output("t3_exhausted", 256'(exhausted), 256'd0);
    check_output("t3_password", password, 256'h006300620061);
    check_output("t3_pw_len", 256'(pw_len), 256'd3);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t3_exh_hold", 256'(exhausted), 256'd0);

    // Abort together with start, five cycles into RUN
    $display("[TB] abort mid-run");
    target = tgt_none;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b0, 1'b0, make_chunk(256'(i + 32'h100), 32'd32), '0);
    check_output("t4_cand_5", 256'(candidates), 256'd5);
    apply_stimulus(1'b1, 1'b1, make_chunk(256'h200, 32'd32), '0);
    check_output("t4_busy", 256'(busy), 256'd0);
    check_output("t4_gen_run", 256'(gen_run), 256'd0);
    check_output("t4_cand_hold", 256'(candidates), 256'd5);
    apply_stimulus(1'b0, 1'b0, make_chunk(256'h201, 32'd32), '0);
    check_output("t4_idle_busy", 256'(busy), 256'd0);
    check_output("t4_idle_cand", 256'(candidates), 256'd5);
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t4_restart_cand", 256'(candidates), 256'd0);
    check_output("t4_restart_busy", 256'(busy), 256'd1);

    // Asynchronous reset while draining
    $display("[TB] async reset mid-drain");
    apply_stimulus(1'b0, 1'b0, c_a, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t5_drain_gen_run", 256'(gen_run), 256'd0);
    check_output("t5_drain_busy", 256'(busy), 256'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("t5_rst_busy", 256'(busy), 256'd0);
    check_output("t5_rst_gen_run", 256'(gen_run), 256'd0);
    check_output("t5_rst_cand", 256'(candidates), 256'd0);
    check_output("t5_rst_found", 256'(found), 256'd0);
    check_output("t5_rst_password", password, 256'd0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b0, '0, '0);
    check_output("t5_fresh_busy", 256'(busy), 256'd1);
    check_output("t5_fresh_cand", 256'(candidates), 256'd0);
    apply_stimulus(1'b0, 1'b0, c_a, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t5_fresh_drop", 256'(gen_run), 256'd0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t5_fresh_exh_early", 256'(exhausted), 256'd0);
    apply_stimulus(1'b0, 1'b0, '0, '0);
    check_output("t5_fresh_exh", 256'(exhausted), 256'd1);
    check_output("t5_fresh_found", 256'(found), 256'd0);
    check_output("t5_fresh_cand_1", 256'(candidates), 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_candidate_tracker.md
Name: md5_candidate_tracker

Overview:
- Sits downstream of the printable UTF-16LE chunk generator and alongside the fully pipelined MD5 hash core.
- Controls the generator's run/reset line and tracks each 512-bit candidate chunk through a delay line that matches the hash latency.
- Compares each emerging digest against the target digest, and on a hit latches the decoded password and halts the search.
- Also detects generator exhaustion (all-zero chunk), drains in-flight candidates, and keeps a candidate count.

Parameters:
- LATENCY, 64: cycles from chunk_in sample to the matching digest_in; delay-line depth (>=1).
- CNT_W, 48: width of the candidate counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle pulse that begins a search
- abort  in  1  single-cycle pulse that cancels a search and returns to IDLE
- target  in  128  digest to match; held stable while busy
- chunk_in  in  512  generator output chunk
- digest_in  in  128  hash core output for the chunk_in presented LATENCY cycles earlier
- gen_run  out  1  drives the generator's active-low reset; 0 holds the generator cleared
- busy  out  1  high in RUN or DRAIN
- found  out  1  sticky: match found
- exhausted  out  1  sticky: search space ended with no match
- password  out  256  matched UTF-16LE bytes, byte 0 at [7:0]; bytes at or beyond 2*pw_len forced to 0
- pw_len  out  5  matched length in characters, 1..16
- candidates  out  CNT_W  number of valid chunks pushed; saturates at all-ones

Behaviour:
Reset (asynchronous, reset=0):
- State IDLE; all outputs 0; all delay-line valid bits 0.

Delay line:
- LATENCY entries, each holding {valid, bytes chunk_in[255:0], len = chunk_in[479:448] >> 4 (5 bits)}.
- Shifts every cycle.
- Push value: valid = (state==RUN) && (chunk_in[479:448] != 0); data is pushed regardless of valid.
- The tail in cycle t carries the push from cycle t-LATENCY.

hit (combinational):
- hit = tail.valid && (digest_in == target) && state in {RUN, DRAIN}.

States:
- IDLE:
  - gen_run=0, busy=0.
  - start -> RUN: clear found, exhausted, candidates, and all valid bits.
- RUN:
  - gen_run=1, busy=1.
  - Each valid push increments candidates, saturating.
  - If hit -> FOUND.
  - Else if gen_run was already 1 last cycle and chunk_in == 0 (generator exhausted) -> DRAIN. That chunk is not pushed (valid=0). The first-cycle zero chunk right after release from reset does not count.
- DRAIN:
  - gen_run=0, busy=1, no valid pushes.
  - If hit -> FOUND.
  - Else, when all valid bits are 0 -> EXHAUSTED.
- FOUND:
  - On entry edge: latch password from tail bytes masked by tail.len, latch pw_len=tail.len, set found=1, set gen_run=0.
  - Clear all valid bits.
  - Holds until start or abort.
- EXHAUSTED:
  - exhausted=1, gen_run=0.
  - Holds until start or abort.

Priorities and edge cases:
- abort in any state -> IDLE on the next edge.
  - Clears valid bits and gen_run.
  - found, exhausted, password, pw_len and candidates keep their values.
- abort and start in the same cycle: abort wins.
- start in FOUND, EXHAUSTED or IDLE restarts the search: counters and flags clear, next state RUN.
- start in RUN or DRAIN is ignored.
- hit and exhaustion in the same cycle: hit wins, and found is set rather than exhausted.
- Only the first hit is reported; later tail entries are discarded.
- Multiple hits are impossible after FOUND because valid bits are cleared.
- target or LATENCY mismatch is outside this block's concern.
- Asynchronous reset mid-search: immediate return to IDLE values with gen_run=0, so the generator is also cleared.
- Latency:
  - found rises on the edge after the hit cycle.
  - A match on the first candidate (pushed at cycle c) gives found=1 at edge c+LATENCY+1.

Test Plan:
- Match on first candidate: LATENCY=4, target=MD5 of the chunk with "!!" replaced by the 1-char candidate 'A'. Pulse start, drive chunk_in with word0=0x0041, 0x80 at byte 2, size 16, and digest_in=target 4 cycles later. Required: found=1 one cycle after the hit, pw_len=1, password=0x0041, gen_run=0, candidates=1.
- No match then exhaustion: feed 10 valid chunks, then chunk_in=0, with digest_in never equal to target. Required: gen_run drops the cycle after the zero chunk, exhausted=1 after LATENCY drain cycles, found=0, candidates=10.
- Hit during DRAIN: matching candidate is the last one before chunk_in=0. Required: found=1, exhausted=0, the matched bytes are latched.
- Masking: 3-char candidate 0x0061,0x0062,0x0063 with padding 0x80 at byte 6. Required on match: password[47:0]=0x006300620061, password[255:48]=0, pw_len=3.
- Abort mid-RUN: 5 cycles into RUN, pulse abort together with start. Required: IDLE next edge, gen_run=0, busy=0, candidates holds 5. A later start clears candidates to 0.
- Async reset: assert reset=0 mid-DRAIN. Required: all outputs 0 immediately. After release a start pulse behaves as a fresh search.
